// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the byte-stream-to-Wishbone bridge.
// Holds the command/status byte values, the FSM state encoding and a
// helper that picks one byte of a 32-bit word in MSB-first order.
package wb_cmd_master_pkg;

    // Command bytes arriving from the host link
    localparam logic [7:0] CMD_RD    = 8'h52;  // 'R'
    localparam logic [7:0] CMD_WR    = 8'h57;  // 'W'

    // Status bytes returned to the host link
    localparam logic [7:0] ST_OK     = 8'h4B;  // 'K'
    localparam logic [7:0] ST_ERR    = 8'h45;  // 'E'
    localparam logic [7:0] ST_BADCMD = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_WDATA     = 3'd2,
        S_BUS       = 3'd3,
        S_RESP_STAT = 3'd4,
        S_RESP_DATA = 3'd5
    } state_e;

    // Byte idx of a word, idx 0 being the most significant byte
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Signal bundle for wb_cmd_master: the host byte link (rx/tx streams) and
// the Wishbone classic master port.
//   master modport : the bridge's view (drives rx_ready, tx_*, wbm_*_o)
//   slave  modport : the environment's view (host link and bus slave)
interface wb_cmd_master_if;

    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, wbm_dat_i, wbm_ack_i,
        output rx_ready_o, tx_data_o, tx_valid_o,
               wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, wbm_dat_i, wbm_ack_i,
        input  rx_ready_o, tx_data_o, tx_valid_o,
               wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o
    );

endinterface

// File: rtl/wb_cmd_timeout.sv
// Bus-cycle watchdog counter for wb_cmd_master.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (has priority over en)
//   en         : count one more cycle without acknowledge
//   expired    : the current cycle is the TIMEOUT-th cycle without ack
// The counter holds the number of completed wait cycles, so the cycle in
// which it reads TIMEOUT-1 is the last one the strobe may stay high.
module wb_cmd_timeout #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle counter: cleared outside the bus phase, counts while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LIMIT);

endmodule

// File: rtl/wb_cmd_master.sv
// Byte-stream-to-Wishbone bridge. Parses 'R'/'W' commands from a host byte
// link, runs a single Wishbone classic cycle and returns a status byte
// ('K', 'E' or '?') plus four read-data bytes for a successful read.
//   wb_clk_i : clock
//   wb_rst_i : asynchronous active-low reset
//   bus      : host rx/tx byte streams and Wishbone master signals
//   busy_o   : high whenever the FSM is outside IDLE
// All outputs come straight from registers.
module wb_cmd_master #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_cmd_master_if.master   bus,
    output logic              busy_o
);

    import wb_cmd_master_pkg::*;

    state_e      state_r;
    logic [1:0]  cnt_r;
    logic        we_r;
    logic [31:0] adr_r;
    logic [31:0] wdat_r;
    logic [31:0] rdat_r;
    logic [7:0]  status_r;
    logic        rx_ready_r;
    logic        tx_valid_r;
    logic [7:0]  tx_data_r;
    logic        cyc_r;
    logic        bus_we_r;
    logic        busy_r;

    logic        accept_s;
    logic        tx_hs_s;
    logic        to_clr_s;
    logic        to_en_s;
    logic        expired_s;

    assign accept_s = bus.rx_valid_i & rx_ready_r;
    assign tx_hs_s  = tx_valid_r & bus.tx_ready_i;
    assign to_clr_s = (state_r != S_BUS);
    assign to_en_s  = (state_r == S_BUS) & ~bus.wbm_ack_i;

    wb_cmd_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_i),
        .clr     (to_clr_s),
        .en      (to_en_s),
        .expired (expired_s)
    );

    // Command FSM; every output register is set for the state being entered
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_r    <= S_IDLE;
            cnt_r      <= 2'd0;
            we_r       <= 1'b0;
            adr_r      <= 32'h0000_0000;
            wdat_r     <= 32'h0000_0000;
            rdat_r     <= 32'h0000_0000;
            status_r   <= 8'h00;
            rx_ready_r <= 1'b1;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            cyc_r      <= 1'b0;
            bus_we_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        busy_r <= 1'b1;
                        if ((bus.rx_data_i == CMD_RD) || (bus.rx_data_i == CMD_WR)) begin
                            we_r    <= (bus.rx_data_i == CMD_WR);
                            cnt_r   <= 2'd0;
                            state_r <= S_ADDR;
                        end else begin
                            status_r   <= ST_BADCMD;
                            tx_data_r  <= ST_BADCMD;
                            tx_valid_r <= 1'b1;
                            rx_ready_r <= 1'b0;
                            state_r    <= S_RESP_STAT;
                        end
                    end
                end

                S_ADDR: begin
                    if (accept_s) begin
                        adr_r <= {adr_r[23:0], bus.rx_data_i};
                        // Counter wraps 3 -> 0, ready for the data phase
                        cnt_r <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            if (we_r) begin
                                state_r <= S_WDATA;
                            end else begin
                                rx_ready_r <= 1'b0;
                                cyc_r      <= 1'b1;
                                bus_we_r   <= 1'b0;
                                state_r    <= S_BUS;
                            end
                        end
                    end
                end

                S_WDATA: begin
                    if (accept_s) begin
                        wdat_r <= {wdat_r[23:0], bus.rx_data_i};
                        cnt_r  <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            rx_ready_r <= 1'b0;
                            cyc_r      <= 1'b1;
                            bus_we_r   <= 1'b1;
                            state_r    <= S_BUS;
                        end
                    end
                end

                S_BUS: begin
                    // Ack is checked first so it wins over a simultaneous timeout
                    if (bus.wbm_ack_i) begin
                        rdat_r     <= bus.wbm_dat_i;
                        cyc_r      <= 1'b0;
                        bus_we_r   <= 1'b0;
                        status_r   <= ST_OK;
                        tx_data_r  <= ST_OK;
                        tx_valid_r <= 1'b1;
                        state_r    <= S_RESP_STAT;
                    end else if (expired_s) begin
                        cyc_r      <= 1'b0;
                        bus_we_r   <= 1'b0;
                        status_r   <= ST_ERR;
                        tx_data_r  <= ST_ERR;
                        tx_valid_r <= 1'b1;
                        state_r    <= S_RESP_STAT;
                    end
                end

                S_RESP_STAT: begin
                    if (tx_hs_s) begin
                        if ((status_r == ST_OK) && !we_r) begin
                            cnt_r     <= 2'd0;
                            tx_data_r <= word_byte(rdat_r, 2'd0);
                            state_r   <= S_RESP_DATA;
                        end else begin
                            tx_valid_r <= 1'b0;
                            rx_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= S_IDLE;
                        end
                    end
                end

                S_RESP_DATA: begin
                    if (tx_hs_s) begin
                        cnt_r <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            tx_valid_r <= 1'b0;
                            rx_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= S_IDLE;
                        end else begin
                            tx_data_r <= word_byte(rdat_r, cnt_r + 2'd1);
                        end
                    end
                end

                default: begin
                    state_r    <= S_IDLE;
                    cnt_r      <= 2'd0;
                    rx_ready_r <= 1'b1;
                    tx_valid_r <= 1'b0;
                    cyc_r      <= 1'b0;
                    bus_we_r   <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready_o = rx_ready_r;
    assign bus.tx_valid_o = tx_valid_r;
    assign bus.tx_data_o  = tx_data_r;
    assign bus.wbm_adr_o  = {adr_r[31:2], 2'b00};
    assign bus.wbm_dat_o  = wdat_r;
    assign bus.wbm_sel_o  = {4{cyc_r}};
    assign bus.wbm_we_o   = bus_we_r;
    assign bus.wbm_cyc_o  = cyc_r;
    assign bus.wbm_stb_o  = cyc_r;
    assign busy_o         = busy_r;

endmodule
